// File: rtl/spi_frame_ctrl.sv
// Frame sequencer for the SPI/QSPI datapath: walks CMD/ADDR/ALTR/NOP/DATA phases, one segment each.
// Optional stall watchdog: define SPI_FRAME_STALL_TIMEOUT_EN to abort frames stuck on TX empty / RX full.
module spi_frame_ctrl #(
    parameter int unsigned NSS_NUM = 1
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic               en_i,
    input  logic               start_i,
    input  logic               abort_i,
    input  logic               rwm_i,
    input  logic               ass_i,
    input  logic [NSS_NUM-1:0] nss_sel_i,
    input  logic [13:0]        frame_i,
    input  logic [7:0]         cmd_i,
    input  logic [31:0]        addr_i,
    input  logic [31:0]        altr_i,
    input  logic [15:0]        nop_i,
    input  logic [15:0]        trl_i,
    output logic               seg_valid_o,
    input  logic               seg_ready_i,
    input  logic               seg_done_i,
    output logic [1:0]         seg_mode_o,
    output logic               seg_dir_o,
    output logic [15:0]        seg_len_o,
    output logic [31:0]        seg_dat_o,
    input  logic [31:0]        rx_dat_i,
    output logic               tx_rd_o,
    input  logic [31:0]        tx_dat_i,
    input  logic               tx_empty_i,
    output logic               rx_wr_o,
    output logic [31:0]        rx_dat_o,
    input  logic               rx_full_i,
    output logic [NSS_NUM-1:0] nss_o,
    output logic               busy_o,
    output logic               done_o,
    output logic               err_o
);

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StCmd   = 3'd1,
        StAddr  = 3'd2,
        StAltr  = 3'd3,
        StNop   = 3'd4,
        StWdata = 3'd5,
        StRdata = 3'd6
    } state_e;

    typedef enum logic [1:0] {StepIssue, StepHold, StepWait} step_e;

    state_e             state_q, state_d;
    step_e              step_q, step_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic [NSS_NUM-1:0] nss_q, nss_d;
    logic [13:0]        frame_q, frame_d;
    logic [7:0]         cmd_q, cmd_d;
    logic [31:0]        addr_q, addr_d;
    logic [31:0]        altr_q, altr_d;
    logic [15:0]        nop_q, nop_d;
    logic               rwm_q, rwm_d;
    logic [15:0]        cnt_q, cnt_d;
    logic [31:0]        wdat_q, wdat_d;

    logic        can_issue, data_st, abort, timeout;
    logic [1:0]  seg_mode;
    logic        seg_dir;
    logic [15:0] seg_len;
    logic [31:0] seg_dat;
    state_e      nxt;

    function automatic logic [15:0] size_bits(input logic [1:0] size);
        case (size)
            2'b00:   return 16'd8;
            2'b01:   return 16'd16;
            2'b10:   return 16'd24;
            default: return 16'd32;
        endcase
    endfunction

    function automatic logic [15:0] lane_len(input logic [15:0] bits, input logic [1:0] mode);
        case (mode)
            2'b10:   return bits >> 1;
            2'b11:   return bits >> 2;
            default: return bits;
        endcase
    endfunction

    function automatic logic [31:0] msb_align(input logic [31:0] val, input logic [1:0] size);
        return val << {2'd3 - size, 3'b000};
    endfunction

    // First enabled phase strictly after cur; StIdle means the frame is finished.
    function automatic state_e next_phase(input state_e cur, input logic [13:0] f,
                                          input logic [15:0] nop, input logic [15:0] trl,
                                          input logic rwm);
        if (cur < StCmd && f[1:0] != 2'b00) return StCmd;
        if (cur < StAddr && f[3:2] != 2'b00) return StAddr;
        if (cur < StAltr && f[7:6] != 2'b00) return StAltr;
        if (cur < StNop && nop != 16'd0) return StNop;
        if (cur < StWdata && f[11:10] != 2'b00 && trl != 16'd0) return rwm ? StRdata : StWdata;
        return StIdle;
    endfunction

    always_comb begin
        seg_mode  = 2'b00;
        seg_dir   = 1'b0;
        seg_len   = 16'd0;
        seg_dat   = 32'd0;
        can_issue = 1'b1;
        case (state_q)
            StCmd: begin
                seg_mode = frame_q[1:0];
                seg_len  = lane_len(16'd8, seg_mode);
                seg_dat  = {cmd_q, 24'h0};
            end
            StAddr: begin
                seg_mode = frame_q[3:2];
                seg_len  = lane_len(size_bits(frame_q[5:4]), seg_mode);
                seg_dat  = msb_align(addr_q, frame_q[5:4]);
            end
            StAltr: begin
                seg_mode = frame_q[7:6];
                seg_len  = lane_len(size_bits(frame_q[9:8]), seg_mode);
                seg_dat  = msb_align(altr_q, frame_q[9:8]);
            end
            StNop: begin
                seg_mode = (frame_q[11:10] == 2'b00) ? 2'b01 : frame_q[11:10];
                seg_dir  = 1'b1;
                seg_len  = nop_q;
            end
            StWdata: begin
                seg_mode  = frame_q[11:10];
                seg_len   = lane_len(size_bits(frame_q[13:12]), seg_mode);
                // FIFO head is only valid in the pop cycle; hold the captured copy afterwards.
                seg_dat   = (step_q == StepIssue) ? msb_align(tx_dat_i, frame_q[13:12]) : wdat_q;
                can_issue = !tx_empty_i;
            end
            StRdata: begin
                seg_mode  = frame_q[11:10];
                seg_dir   = 1'b1;
                seg_len   = lane_len(size_bits(frame_q[13:12]), seg_mode);
                can_issue = !rx_full_i;
            end
            default: ;
        endcase
    end

    assign data_st     = (state_q == StWdata) || (state_q == StRdata);
    assign seg_valid_o = (state_q != StIdle) &&
                         ((step_q == StepHold) || (step_q == StepIssue && can_issue));
    assign seg_mode_o  = seg_mode;
    assign seg_dir_o   = seg_dir;
    assign seg_len_o   = seg_len;
    assign seg_dat_o   = seg_dat;
    assign tx_rd_o     = (state_q == StWdata) && (step_q == StepIssue) && !tx_empty_i;
    assign rx_wr_o     = (state_q == StRdata) && (step_q == StepWait) && seg_done_i;
    assign rx_dat_o    = rx_dat_i;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign err_o       = err_q;
    assign nss_o       = nss_q;

`ifdef SPI_FRAME_STALL_TIMEOUT_EN
    logic [15:0] stall_q, stall_d;
    logic        stall;

    assign stall   = (state_q != StIdle) && (step_q == StepIssue) && !can_issue;
    assign stall_d = stall ? stall_q + 16'd1 : 16'd0;
    assign timeout = (stall_q == 16'hFFFF);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) stall_q <= 16'd0;
        else          stall_q <= stall_d;
    end
`else
    assign timeout = 1'b0;
`endif

    assign abort = abort_i || !en_i || timeout;

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        err_d   = err_q;
        frame_d = frame_q;
        cmd_d   = cmd_q;
        addr_d  = addr_q;
        altr_d  = altr_q;
        nop_d   = nop_q;
        rwm_d   = rwm_q;
        cnt_d   = cnt_q;
        wdat_d  = wdat_q;
        nxt     = state_q;
        if (state_q == StIdle) begin
            step_d = StepIssue;
            if (busy_q) begin
                // Every phase was skipped: close the frame one cycle after start.
                busy_d = 1'b0;
                done_d = 1'b1;
            end else if (start_i && en_i) begin
                frame_d = frame_i;
                cmd_d   = cmd_i;
                addr_d  = addr_i;
                altr_d  = altr_i;
                nop_d   = nop_i;
                rwm_d   = rwm_i;
                cnt_d   = trl_i;
                err_d   = 1'b0;
                busy_d  = 1'b1;
                state_d = next_phase(StIdle, frame_i, nop_i, trl_i, rwm_i);
            end
        end else if (abort) begin
            state_d = StIdle;
            step_d  = StepIssue;
            busy_d  = 1'b0;
            err_d   = 1'b1;
        end else begin
            case (step_q)
                StepIssue: begin
                    if (can_issue) begin
                        if (state_q == StWdata) wdat_d = seg_dat;
                        step_d = seg_ready_i ? StepWait : StepHold;
                    end
                end
                StepHold: if (seg_ready_i) step_d = StepWait;
                StepWait: begin
                    if (seg_done_i) begin
                        step_d = StepIssue;
                        if (data_st) begin
                            cnt_d = cnt_q - 16'd1;
                            nxt   = (cnt_q == 16'd1) ? StIdle : state_q;
                        end else begin
                            nxt = next_phase(state_q, frame_q, nop_q, cnt_q, rwm_q);
                        end
                        state_d = nxt;
                        if (nxt == StIdle) begin
                            busy_d = 1'b0;
                            done_d = 1'b1;
                        end
                    end
                end
                default: step_d = StepIssue;
            endcase
        end
        nss_d = ass_i ? (busy_d ? ~nss_sel_i : '1) : ~nss_sel_i;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= StIdle;
            step_q  <= StepIssue;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            nss_q   <= '1;
            frame_q <= 14'd0;
            cmd_q   <= 8'd0;
            addr_q  <= 32'd0;
            altr_q  <= 32'd0;
            nop_q   <= 16'd0;
            rwm_q   <= 1'b0;
            cnt_q   <= 16'd0;
            wdat_q  <= 32'd0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            nss_q   <= nss_d;
            frame_q <= frame_d;
            cmd_q   <= cmd_d;
            addr_q  <= addr_d;
            altr_q  <= altr_d;
            nop_q   <= nop_d;
            rwm_q   <= rwm_d;
            cnt_q   <= cnt_d;
            wdat_q  <= wdat_d;
        end
    end

endmodule

// File: tb/tb_spi_frame_ctrl.sv
// Scoreboard bench for spi_frame_ctrl: directed frames, a simple shift-engine model and a TX FIFO model.
module tb_spi_frame_ctrl;

    localparam int unsigned NSS_NUM = 1;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               en_i, start_i, abort_i, rwm_i, ass_i;
    logic [NSS_NUM-1:0] nss_sel_i;
    logic [13:0]        frame_i;
    logic [7:0]         cmd_i;
    logic [31:0]        addr_i, altr_i;
    logic [15:0]        nop_i, trl_i;
    logic               seg_valid_o, seg_ready_i, seg_done_i;
    logic [1:0]         seg_mode_o;
    logic               seg_dir_o;
    logic [15:0]        seg_len_o;
    logic [31:0]        seg_dat_o, rx_dat_i;
    logic               tx_rd_o, tx_empty_i, rx_wr_o, rx_full_i;
    logic [31:0]        tx_dat_i, rx_dat_o;
    logic [NSS_NUM-1:0] nss_o;
    logic               busy_o, done_o, err_o;

    always #5 clk = ~clk;

    spi_frame_ctrl #(.NSS_NUM(NSS_NUM)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .en_i(en_i), .start_i(start_i), .abort_i(abort_i),
        .rwm_i(rwm_i), .ass_i(ass_i), .nss_sel_i(nss_sel_i), .frame_i(frame_i), .cmd_i(cmd_i),
        .addr_i(addr_i), .altr_i(altr_i), .nop_i(nop_i), .trl_i(trl_i),
        .seg_valid_o(seg_valid_o), .seg_ready_i(seg_ready_i), .seg_done_i(seg_done_i),
        .seg_mode_o(seg_mode_o), .seg_dir_o(seg_dir_o), .seg_len_o(seg_len_o),
        .seg_dat_o(seg_dat_o), .rx_dat_i(rx_dat_i), .tx_rd_o(tx_rd_o), .tx_dat_i(tx_dat_i),
        .tx_empty_i(tx_empty_i), .rx_wr_o(rx_wr_o), .rx_dat_o(rx_dat_o), .rx_full_i(rx_full_i),
        .nss_o(nss_o), .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
    );

    typedef enum int {EvSeg, EvTxrd, EvRxw, EvDone} ev_kind_e;
    typedef struct {
        ev_kind_e    kind;
        logic [1:0]  mode;
        logic        dir;
        logic [15:0] len;
        logic [31:0] dat;
    } ev_t;

    ev_t         sb[$];
    logic [31:0] tx_q[$];
    int          passes = 0;
    int          total = 0;
    int          done_cnt = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passes++;
        else $display("FAIL %s: got %h, expected %h", name, got, exp);
    endtask

    task automatic push(input ev_kind_e k, input logic [1:0] m, input logic d,
                        input logic [15:0] l, input logic [31:0] dt);
        ev_t e;
        e.kind = k; e.mode = m; e.dir = d; e.len = l; e.dat = dt;
        sb.push_back(e);
    endtask

    task automatic sb_check(input ev_t got);
        ev_t e;
        bit  ok;
        total++;
        if (sb.size() == 0) begin
            $display("FAIL sb unexpected event: got kind=%0d len=%0d dat=%h, expected none",
                     got.kind, got.len, got.dat);
        end else begin
            e  = sb.pop_front();
            ok = (e.kind == got.kind);
            if (ok && got.kind == EvSeg)
                ok = (e.mode == got.mode) && (e.dir == got.dir) && (e.len == got.len) &&
                     (e.dat == got.dat);
            if (ok && got.kind == EvRxw) ok = (e.dat == got.dat);
            if (ok) passes++;
            else $display("FAIL sb event: got kind=%0d mode=%0d dir=%0d len=%0d dat=%h, expected kind=%0d mode=%0d dir=%0d len=%0d dat=%h",
                          got.kind, got.mode, got.dir, got.len, got.dat,
                          e.kind, e.mode, e.dir, e.len, e.dat);
        end
    endtask

    // Monitor: observe DUT outputs on the falling edge and compare against the scoreboard.
    initial begin
        ev_t g;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                g.mode = 2'b00; g.dir = 1'b0; g.len = 16'd0; g.dat = 32'd0;
                if (tx_rd_o) begin g.kind = EvTxrd; sb_check(g); end
                if (seg_valid_o && seg_ready_i) begin
                    g.kind = EvSeg; g.mode = seg_mode_o; g.dir = seg_dir_o;
                    g.len = seg_len_o; g.dat = seg_dat_o;
                    sb_check(g);
                    check("seg nss", 32'(nss_o), 32'd0);
                end
                if (rx_wr_o) begin
                    g.kind = EvRxw; g.mode = 2'b00; g.dir = 1'b0; g.len = 16'd0; g.dat = rx_dat_o;
                    sb_check(g);
                end
                if (done_o) begin g.kind = EvDone; g.dat = 32'd0; sb_check(g); end
            end
        end
    end

    // Shift engine model: done three cycles after acceptance, rx data tagged by done index.
    initial begin
        bit acc;
        int eng_cnt;
        eng_cnt = 0;
        seg_done_i = 1'b0;
        rx_dat_i = 32'd0;
        forever begin
            @(negedge clk);
            acc = seg_valid_o && seg_ready_i && rst_n;
            @(posedge clk);
            #1;
            seg_done_i = 1'b0;
            if (eng_cnt > 0) begin
                eng_cnt--;
                if (eng_cnt == 0) begin
                    seg_done_i = 1'b1;
                    rx_dat_i = 32'h5A00_0000 | 32'(done_cnt);
                    done_cnt++;
                end
            end
            if (acc) eng_cnt = 3;
        end
    end

    // TX FIFO model.
    initial begin
        bit pop;
        tx_empty_i = 1'b1;
        tx_dat_i = 32'd0;
        forever begin
            @(negedge clk);
            pop = tx_rd_o;
            @(posedge clk);
            #1;
            if (pop && tx_q.size() > 0) void'(tx_q.pop_front());
            tx_empty_i = (tx_q.size() == 0);
            tx_dat_i = (tx_q.size() > 0) ? tx_q[0] : 32'd0;
        end
    end

    initial begin
        #3ms;
        $display("FAIL watchdog: got simulation still running, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [13:0] mk_frame(input logic [1:0] dsize, input logic [1:0] dmode,
                                             input logic [1:0] alsize, input logic [1:0] almode,
                                             input logic [1:0] asize, input logic [1:0] amode,
                                             input logic [1:0] cmode);
        return {dsize, dmode, alsize, almode, asize, amode, cmode};
    endfunction

    task automatic start_frame(input logic [13:0] f, input logic [7:0] c, input logic [31:0] a,
                               input logic [15:0] n, input logic [15:0] t, input logic r);
        frame_i = f; cmd_i = c; addr_i = a; nop_i = n; trl_i = t; rwm_i = r;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
    endtask

    task automatic wait_frame_end(input string name);
        bit ended = 0;
        for (int i = 0; i < 400 && !ended; i++) begin
            @(negedge clk);
            if (!busy_o) ended = 1;
        end
        check({name, " end"}, 32'(ended), 32'd1);
        repeat (6) tick();
        check({name, " sb drained"}, 32'(sb.size()), 32'd0);
    endtask

    task automatic wait_valid(input string name, input logic [15:0] len);
        bit seen = 0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            if (seg_valid_o && seg_len_o == len) seen = 1;
        end
        check(name, 32'(seen), 32'd1);
    endtask

    initial begin
        rst_n = 1'b0; en_i = 1'b1; start_i = 1'b0; abort_i = 1'b0; rwm_i = 1'b0;
        ass_i = 1'b1; nss_sel_i = '1; frame_i = 14'd0; cmd_i = 8'd0; addr_i = 32'd0;
        altr_i = 32'hCAFE_F00D; nop_i = 16'd0; trl_i = 16'd0; seg_ready_i = 1'b1;
        rx_full_i = 1'b0;
        repeat (3) @(negedge clk);
        check("rst seg_valid", 32'(seg_valid_o), 32'd0);
        check("rst seg_len", 32'(seg_len_o), 32'd0);
        check("rst seg_dat", seg_dat_o, 32'd0);
        check("rst tx_rd", 32'(tx_rd_o), 32'd0);
        check("rst rx_wr", 32'(rx_wr_o), 32'd0);
        check("rst nss", 32'(nss_o), 32'd1);
        check("rst busy", 32'(busy_o), 32'd0);
        check("rst done", 32'(done_o), 32'd0);
        check("rst err", 32'(err_o), 32'd0);
        tick();
        rst_n = 1'b1;
        repeat (2) tick();

        // Manual slave select follows CTRL.NSS even when idle.
        ass_i = 1'b0;
        tick();
        @(negedge clk);
        check("nss manual", 32'(nss_o), 32'd0);
        ass_i = 1'b1;
        tick();
        @(negedge clk);
        check("nss auto idle", 32'(nss_o), 32'd1);
        tick();

        // Quad read: CMD std, ADDR 24b quad, 6 dummy cycles, 2 x 32b quad data words.
        done_cnt = 0;
        push(EvSeg, 2'b01, 1'b0, 16'd8, 32'hEB00_0000);
        push(EvSeg, 2'b11, 1'b0, 16'd6, 32'h1234_5600);
        push(EvSeg, 2'b11, 1'b1, 16'd6, 32'h0);
        push(EvSeg, 2'b11, 1'b1, 16'd8, 32'h0);
        push(EvRxw, 2'b00, 1'b0, 16'd0, 32'h5A00_0003);
        push(EvSeg, 2'b11, 1'b1, 16'd8, 32'h0);
        push(EvRxw, 2'b00, 1'b0, 16'd0, 32'h5A00_0004);
        push(EvDone, 2'b00, 1'b0, 16'd0, 32'h0);
        start_frame(mk_frame(2'b11, 2'b11, 2'b00, 2'b00, 2'b10, 2'b11, 2'b01),
                    8'hEB, 32'h0012_3456, 16'd6, 16'd2, 1'b1);
        wait_frame_end("quad read");

        // Std write: CMD, ADDR 24b, three 8-bit words from a preloaded TX FIFO.
        tx_q.push_back(32'h0000_00A1);
        tx_q.push_back(32'h0000_00B2);
        tx_q.push_back(32'h0000_00C3);
        repeat (2) tick();
        push(EvSeg, 2'b01, 1'b0, 16'd8, 32'h0200_0000);
        push(EvSeg, 2'b01, 1'b0, 16'd24, 32'hABCD_EF00);
        push(EvTxrd, 2'b00, 1'b0, 16'd0, 32'h0);
        push(EvSeg, 2'b01, 1'b0, 16'd8, 32'hA100_0000);
        push(EvTxrd, 2'b00, 1'b0, 16'd0, 32'h0);
        push(EvSeg, 2'b01, 1'b0, 16'd8, 32'hB200_0000);
        push(EvTxrd, 2'b00, 1'b0, 16'd0, 32'h0);
        push(EvSeg, 2'b01, 1'b0, 16'd8, 32'hC300_0000);
        push(EvDone, 2'b00, 1'b0, 16'd0, 32'h0);
        start_frame(mk_frame(2'b00, 2'b01, 2'b00, 2'b00, 2'b10, 2'b01, 2'b01),
                    8'h02, 32'h00AB_CDEF, 16'd0, 16'd3, 1'b0);
        wait_frame_end("std write");
        check("tx drained", 32'(tx_q.size()), 32'd0);

        // Data-only write that underruns after the first word.
        tx_q.push_back(32'h1111_2222);
        repeat (2) tick();
        push(EvTxrd, 2'b00, 1'b0, 16'd0, 32'h0);
        push(EvSeg, 2'b01, 1'b0, 16'd32, 32'h1111_2222);
        push(EvTxrd, 2'b00, 1'b0, 16'd0, 32'h0);
        push(EvSeg, 2'b01, 1'b0, 16'd32, 32'h3333_4444);
        push(EvDone, 2'b00, 1'b0, 16'd0, 32'h0);
        start_frame(mk_frame(2'b11, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00),
                    8'h00, 32'h0, 16'd0, 16'd2, 1'b0);
        repeat (15) tick();
        @(negedge clk);
        check("stall seg_valid", 32'(seg_valid_o), 32'd0);
        check("stall nss", 32'(nss_o), 32'd0);
        check("stall busy", 32'(busy_o), 32'd1);
        tick();
        tx_q.push_back(32'h3333_4444);
        wait_frame_end("tx underrun");

        // All phases skipped (DMODE set but trl=0): done two cycles after start.
        push(EvDone, 2'b00, 1'b0, 16'd0, 32'h0);
        start_frame(mk_frame(2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00),
                    8'h00, 32'h0, 16'd0, 16'd0, 1'b0);
        @(negedge clk);
        check("skip busy", 32'(busy_o), 32'd1);
        check("skip early done", 32'(done_o), 32'd0);
        @(negedge clk);
        check("skip done", 32'(done_o), 32'd1);
        check("skip busy clr", 32'(busy_o), 32'd0);
        wait_frame_end("all skip");

        // Abort while the ADDR segment is held waiting for ready.
        push(EvSeg, 2'b01, 1'b0, 16'd8, 32'h9F00_0000);
        start_frame(mk_frame(2'b00, 2'b00, 2'b00, 2'b00, 2'b11, 2'b01, 2'b01),
                    8'h9F, 32'hDEAD_BEEF, 16'd0, 16'd0, 1'b0);
        wait_valid("abort cmd valid", 16'd8);
        tick();
        seg_ready_i = 1'b0;
        wait_valid("abort addr valid", 16'd32);
        repeat (2) tick();
        @(negedge clk);
        check("addr hold valid", 32'(seg_valid_o), 32'd1);
        check("addr hold dat", seg_dat_o, 32'hDEAD_BEEF);
        tick();
        abort_i = 1'b1;
        tick();
        abort_i = 1'b0;
        @(negedge clk);
        check("abort seg_valid", 32'(seg_valid_o), 32'd0);
        check("abort nss", 32'(nss_o), 32'd1);
        check("abort err", 32'(err_o), 32'd1);
        check("abort busy", 32'(busy_o), 32'd0);
        check("abort done", 32'(done_o), 32'd0);
        seg_ready_i = 1'b1;
        repeat (6) tick();
        check("abort sb drained", 32'(sb.size()), 32'd0);
        push(EvDone, 2'b00, 1'b0, 16'd0, 32'h0);
        start_frame(mk_frame(2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00),
                    8'h00, 32'h0, 16'd0, 16'd0, 1'b0);
        @(negedge clk);
        check("restart err clr", 32'(err_o), 32'd0);
        wait_frame_end("restart");

`ifdef SPI_FRAME_STALL_TIMEOUT_EN
        // Read stuck on a full RX FIFO aborts after 65535 stall cycles.
        begin
            bit seen = 0;
            int at = 0;
            rx_full_i = 1'b1;
            start_frame(mk_frame(2'b11, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00),
                        8'h00, 32'h0, 16'd0, 16'd1, 1'b1);
            for (int i = 0; i < 70000 && !seen; i++) begin
                @(negedge clk);
                if (err_o) begin seen = 1; at = i; end
            end
            check("timeout err", 32'(seen), 32'd1);
            check("timeout window", 32'(at >= 65530 && at <= 65545), 32'd1);
            check("timeout busy", 32'(busy_o), 32'd0);
            check("timeout nss", 32'(nss_o), 32'd1);
            rx_full_i = 1'b0;
            repeat (4) tick();
            check("timeout sb drained", 32'(sb.size()), 32'd0);
        end
`endif

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
